hazard_scoreboard_unit: RTL
===========================

Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the pipeline hazard detector for the three-stage core.
- Adds N-stage priority forwarding, a per-register scoreboard for outstanding long-latency ops (GEMM/MUL/DIV), an outstanding-op limit, and multi-cycle flush hold.
- Sits in the decode/execute boundary.
- Drives operand-mux selects, pipeline stall and flush.

Parameters:
- NUM_REGS, 32, architectural registers; REG_AW = $clog2(NUM_REGS).
- FWD_STAGES, 2, downstream stages able to forward. Stage 0 is youngest (closest to execute).
- MAX_PENDING, 4, max outstanding long-latency ops (1..NUM_REGS-1).
- FLUSH_CYCLES, 1, cycles flush stays asserted per redirect (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a live instruction
- raddr1, raddr2  in  REG_AW  source registers
- rs1_used, rs2_used  in  1  source actually read
- fwd_rd  in  FWD_STAGES*REG_AW  destination of each downstream stage
- fwd_reg_wr  in  FWD_STAGES  stage writes a register
- fwd_data_rdy  in  FWD_STAGES  stage result available (0 for a load not yet returned)
- issue_long  in  1  decode instruction is a long-latency op
- issue_rd  in  REG_AW  its destination
- long_done  in  1  a long op completes this cycle
- long_done_rd  in  REG_AW  its destination
- branch_taken, epc_taken  in  1  redirect requests
- ext_stall  in  1  external stall (e.g. wait_for_gemm)
- forw_a_sel, forw_b_sel  out  $clog2(FWD_STAGES+1)  0 = regfile, i+1 = forward from stage i
- stall  out  1  hold PC/IF-ID
- flush  out  1  kill decode slot
- pending_cnt  out  $clog2(MAX_PENDING+1)  outstanding long ops
- sb_err  out  1  sticky: completion for a non-busy register
- stall_cycles, flush_events  out  32  performance counters (see optional feature)

Behaviour:
- Reset (async, rst_n=0): busy[] = 0, pending_cnt = 0, flush counter = 0, sb_err = 0, perf counters = 0.
  - Comb outputs reflect the cleared state.
  - Reset mid-operation discards all outstanding ops.
- Forwarding (comb):
  - Stage i matches src when fwd_reg_wr[i] & fwd_data_rdy[i] & fwd_rd[i] != 0 & fwd_rd[i] == src.
  - The lowest matching i wins; sel = i+1, else 0.
  - Register 0 never forwards.
- Load-use hazard: any stage with fwd_reg_wr[i] & !fwd_data_rdy[i] & rd != 0 & rd == a used source.
  - Applies only if no younger stage j<i already supplies that source with ready data.
- Scoreboard hazard: id_valid & used source with busy[src] = 1.
  - Same-cycle long_done to that register does NOT bypass; the stall holds this cycle.
- WAW hazard: id_valid & issue_long & busy[issue_rd].
- Capacity hazard: id_valid & issue_long & issue_rd != 0 & pending_cnt == MAX_PENDING.
  - This stall holds even if long_done is asserted the same cycle.
- stall = ext_stall | ((load-use | scoreboard | WAW | capacity) & ~flush).
- Issue accept = id_valid & issue_long & ~stall & ~flush & issue_rd != 0.
  - On accept: busy[issue_rd] <= 1 and pending_cnt +1.
  - rd = 0 ops are never tracked.
- Completion:
  - long_done with busy[long_done_rd] = 1: clear the bit, pending_cnt -1.
  - If the register is not busy: ignore and set sb_err (cleared only by reset).
  - Accept and completion in the same cycle: counter is net unchanged.
  - Same register issued and completed in the same cycle ends busy.
- Flush:
  - flush = branch_taken | epc_taken | (flush_cnt != 0).
  - On a redirect, flush_cnt <= FLUSH_CYCLES-1.
  - Otherwise flush_cnt decrements to 0.
  - A redirect during hold reloads the counter.
  - Flush does not clear the scoreboard; already-issued long ops still complete.
- Latency: all outputs except pending_cnt/sb_err/counters are combinational from inputs and state. State updates on the next rising clk.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments every cycle stall = 1.
  - flush_events increments on each cycle with branch_taken | epc_taken.
  - Both are 32-bit, wrap at 2^32-1 -> 0, and reset to 0.
- Undefined: both outputs tied to 0 and no counter flops are synthesised. Ports are present in both builds.

Test Plan:
- Forwarding priority (FWD_STAGES=2): fwd_rd={x5,x5}, reg_wr=11, rdy=11, raddr1=5, rs1_used=1 -> forw_a_sel=1, stall=0. With raddr1=0 -> forw_a_sel=0.
- Load-use: stage0 rd=x7, reg_wr=1, rdy=0, raddr2=7, rs2_used=1 -> stall=1. Next cycle rdy=1 -> stall=0, forw_b_sel=1.
- Scoreboard:
  - Issue long op to x9 -> pending_cnt=1.
  - Next instruction reads x9 -> stall=1.
  - long_done_rd=9 -> stall still 1 that cycle, 0 next cycle, pending_cnt=0.
- Capacity (MAX_PENDING=4): accept 4 long ops to x1..x4.
  - 5th issue_long -> stall=1, pending_cnt stays 4.
  - long_done x1 -> next cycle the 5th is accepted, pending_cnt=4.
- Flush (FLUSH_CYCLES=3):
  - branch_taken one cycle while a load-use hazard is present -> flush=1 for 3 cycles, stall=0 during flush.
  - ext_stall=1 during flush -> stall=1.
- Error/reset:
  - long_done_rd=12 with x12 idle -> sb_err=1, pending_cnt unchanged.
  - rst_n low mid-run -> all busy bits, counters and sb_err = 0 immediately.
  - With HAZARD_PERF_CNT_EN, stall_cycles equals the count of stalled cycles observed.

Source files
------------

// File: rtl/hazard_scoreboard_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_unit_if
// Bundles every decode/execute-boundary signal of the hazard scoreboard.
//   master : core side. Drives decode operands, forwarding-stage status,
//            long-op issue/complete and redirects. Receives the mux selects,
//            stall/flush, the pending count, the error flag and the counters.
//   slave  : the hazard_scoreboard_unit itself (mirror of master).
// Parameters must match the ones given to hazard_scoreboard_unit.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_unit_if #(
  parameter int NUM_REGS    = 32,
  parameter int FWD_STAGES  = 2,
  parameter int MAX_PENDING = 4
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int SEL_W  = $clog2(FWD_STAGES + 1);
  localparam int CNT_W  = $clog2(MAX_PENDING + 1);

  // decode slot
  logic                         id_valid;
  logic [REG_AW-1:0]            raddr1;
  logic [REG_AW-1:0]            raddr2;
  logic                         rs1_used;
  logic                         rs2_used;
  // downstream stages, stage 0 is the youngest
  logic [FWD_STAGES*REG_AW-1:0] fwd_rd;
  logic [FWD_STAGES-1:0]        fwd_reg_wr;
  logic [FWD_STAGES-1:0]        fwd_data_rdy;
  // long-latency op tracking
  logic                         issue_long;
  logic [REG_AW-1:0]            issue_rd;
  logic                         long_done;
  logic [REG_AW-1:0]            long_done_rd;
  // redirects and external hold
  logic                         branch_taken;
  logic                         epc_taken;
  logic                         ext_stall;
  // results
  logic [SEL_W-1:0]             forw_a_sel;
  logic [SEL_W-1:0]             forw_b_sel;
  logic                         stall;
  logic                         flush;
  logic [CNT_W-1:0]             pending_cnt;
  logic                         sb_err;
  logic [31:0]                  stall_cycles;
  logic [31:0]                  flush_events;

  modport master (
    output id_valid, raddr1, raddr2, rs1_used, rs2_used,
           fwd_rd, fwd_reg_wr, fwd_data_rdy,
           issue_long, issue_rd, long_done, long_done_rd,
           branch_taken, epc_taken, ext_stall,
    input  forw_a_sel, forw_b_sel, stall, flush,
           pending_cnt, sb_err, stall_cycles, flush_events
  );

  modport slave (
    input  id_valid, raddr1, raddr2, rs1_used, rs2_used,
           fwd_rd, fwd_reg_wr, fwd_data_rdy,
           issue_long, issue_rd, long_done, long_done_rd,
           branch_taken, epc_taken, ext_stall,
    output forw_a_sel, forw_b_sel, stall, flush,
           pending_cnt, sb_err, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_unit
// Decode/execute boundary hazard logic: N-stage priority forwarding,
// load-use detection, a per-register busy scoreboard for long-latency ops
// with an outstanding-op limit, and a multi-cycle flush hold.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset (clears scoreboard, counters)
//   bus    : hazard_scoreboard_unit_if.slave, all operand/status inputs and
//            forw_a_sel/forw_b_sel/stall/flush (combinational) plus
//            pending_cnt/sb_err/stall_cycles/flush_events (registered).
//
// Build option: define HAZARD_PERF_CNT_EN to get the stall_cycles and
// flush_events counters; otherwise both outputs are tied to zero.
// ---------------------------------------------------------------------------
module hazard_scoreboard_unit #(
  parameter int NUM_REGS     = 32,
  parameter int FWD_STAGES   = 2,
  parameter int MAX_PENDING  = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hazard_scoreboard_unit_if.slave bus
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int SEL_W  = $clog2(FWD_STAGES + 1);
  localparam int CNT_W  = $clog2(MAX_PENDING + 1);
  // FLUSH_CYCLES=1 needs no hold state, but keep one bit so the counter exists
  localparam int FC_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [CNT_W-1:0]    PEND_MAX     = CNT_W'(MAX_PENDING);
  localparam logic [FC_W-1:0]     FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [NUM_REGS-1:0] ONE_HOT0     = NUM_REGS'(1);

  // state
  logic [NUM_REGS-1:0] r_busy;
  logic [CNT_W-1:0]    r_pending;
  logic [FC_W-1:0]     r_flush_cnt;
  logic                r_sb_err;

  // combinational
  logic [SEL_W-1:0]    w_sel_a;
  logic [SEL_W-1:0]    w_sel_b;
  logic                w_lu_a;
  logic                w_lu_b;
  logic                w_load_use;
  logic                w_sb_hazard;
  logic                w_waw;
  logic                w_capacity;
  logic                w_redirect;
  logic                w_flush;
  logic                w_stall;
  logic                w_accept;
  logic                w_done_ok;
  logic                w_done_bad;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [CNT_W-1:0]    w_pend_nxt;

  // Scan stages youngest first. The first ready match supplies the operand;
  // a not-ready match seen before it means the value is still in flight.
  // Returns {not_ready_hit, select}.
  function automatic logic [SEL_W:0] resolve_src(
    input logic [REG_AW-1:0]            src,
    input logic [FWD_STAGES*REG_AW-1:0] rd_v,
    input logic [FWD_STAGES-1:0]        wr_v,
    input logic [FWD_STAGES-1:0]        rdy_v
  );
    logic [SEL_W-1:0]  sel;
    logic              lu;
    logic              found;
    logic [REG_AW-1:0] rd;
    sel   = '0;
    lu    = 1'b0;
    found = 1'b0;
    for (int i = 0; i < FWD_STAGES; i++) begin
      rd = rd_v[i*REG_AW +: REG_AW];
      if (!found && wr_v[i] && (rd != '0) && (rd == src)) begin
        if (rdy_v[i]) begin
          sel   = SEL_W'(i + 1);
          found = 1'b1;
        end else begin
          lu = 1'b1;
        end
      end
    end
    return {lu, sel};
  endfunction

  // Forwarding selects and per-source load-use detection
  always_comb begin
    {w_lu_a, w_sel_a} = resolve_src(bus.raddr1, bus.fwd_rd, bus.fwd_reg_wr, bus.fwd_data_rdy);
    {w_lu_b, w_sel_b} = resolve_src(bus.raddr2, bus.fwd_rd, bus.fwd_reg_wr, bus.fwd_data_rdy);
  end

  // Hazard classification, stall and flush
  always_comb begin
    w_redirect  = bus.branch_taken | bus.epc_taken;
    w_flush     = w_redirect | (r_flush_cnt != '0);
    w_load_use  = (bus.rs1_used & w_lu_a) | (bus.rs2_used & w_lu_b);
    // a completion in this same cycle does not bypass the busy bit
    w_sb_hazard = bus.id_valid & ((bus.rs1_used & r_busy[bus.raddr1]) |
                                  (bus.rs2_used & r_busy[bus.raddr2]));
    w_waw       = bus.id_valid & bus.issue_long & r_busy[bus.issue_rd];
    // capacity is judged on the registered count, ignoring a same-cycle completion
    w_capacity  = bus.id_valid & bus.issue_long & (bus.issue_rd != '0) &
                  (r_pending == PEND_MAX);
    w_stall     = bus.ext_stall |
                  ((w_load_use | w_sb_hazard | w_waw | w_capacity) & ~w_flush);
  end

  // Scoreboard next state: issue sets, completion clears
  always_comb begin
    w_accept   = bus.id_valid & bus.issue_long & ~w_stall & ~w_flush & (bus.issue_rd != '0);
    w_done_ok  = bus.long_done & r_busy[bus.long_done_rd];
    w_done_bad = bus.long_done & ~r_busy[bus.long_done_rd];
    w_set_mask = w_accept  ? (ONE_HOT0 << bus.issue_rd)     : '0;
    w_clr_mask = w_done_ok ? (ONE_HOT0 << bus.long_done_rd) : '0;
    // set applied after clear so a same-register issue+complete ends busy
    w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
    case ({w_accept, w_done_ok})
      2'b10:   w_pend_nxt = r_pending + CNT_W'(1);
      2'b01:   w_pend_nxt = r_pending - CNT_W'(1);
      default: w_pend_nxt = r_pending;
    endcase
  end

  // Busy bits and outstanding-op count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_pending <= w_pend_nxt;
    end
  end

  // Flush hold counter, reloaded by every redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= '0;
    end else if (w_redirect) begin
      r_flush_cnt <= FLUSH_RELOAD;
    end else if (r_flush_cnt != '0) begin
      r_flush_cnt <= r_flush_cnt - FC_W'(1);
    end else begin
      r_flush_cnt <= r_flush_cnt;
    end
  end

  // Sticky error on completion of a register that was not busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_err <= 1'b0;
    end else if (w_done_bad) begin
      r_sb_err <= 1'b1;
    end else begin
      r_sb_err <= r_sb_err;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  // Free-running performance counters, wrap naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
      r_flush_events <= 32'd0;
    end else begin
      r_stall_cycles <= r_stall_cycles + {31'd0, w_stall};
      r_flush_events <= r_flush_events + {31'd0, w_redirect};
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_events = r_flush_events;
`else
  assign bus.stall_cycles = 32'd0;
  assign bus.flush_events = 32'd0;
`endif

  assign bus.forw_a_sel  = w_sel_a;
  assign bus.forw_b_sel  = w_sel_b;
  assign bus.stall       = w_stall;
  assign bus.flush       = w_flush;
  assign bus.pending_cnt = r_pending;
  assign bus.sb_err      = r_sb_err;
endmodule
